fir_flow_ctrl: RTL and testbench

//  Flow controller wrapped around one streaming FirFilter instance, which has no backpressure.

---
 rtl/fir_flow_ctrl.sv | 150 +++++++++++++++
 tb/tb_fir_flow_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_flow_ctrl.sv
// Valid/ready flow controller around a fixed-latency streaming FIR with an output FIFO and credit-based input stall.
// Define FIR_FLOW_FLUSH_EN to zero-flush the filter delay line after s_last and tag the final tail result.
module fir_flow_ctrl #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 26,
    parameter int NUM_TAPS     = 37,
    parameter int FIR_LATENCY  = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [INPUT_WIDTH-1:0]  s_data,
    input  logic                    s_last,
    output logic                    fir_valid_in,
    output logic [INPUT_WIDTH-1:0]  fir_din,
    input  logic                    fir_valid_out,
    input  logic [OUTPUT_WIDTH-1:0] fir_dout,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OUTPUT_WIDTH-1:0] m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic                    ovf_err
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

    state_t            state;
    logic [CW-1:0]     inflight, inflight_next;
    logic [CW-1:0]     fifo_count, fifo_count_next;
    logic [CW-1:0]     last_pos;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [OUTPUT_WIDTH:0] mem [FIFO_DEPTH];
    logic [OUTPUT_WIDTH:0] head;
    logic              has_credit, handshake, issue, zero_issue, tag_issue;
    logic              tag_out, pop, full, push_ok, drop;

    // Every result ever issued must already own a FIFO slot, so credit counts in-flight samples too.
    assign has_credit = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH);
    assign s_ready    = rst && (state == RUN) && has_credit;
    assign handshake  = s_valid && s_ready;
    assign issue      = handshake || zero_issue;

`ifdef FIR_FLOW_FLUSH_EN
    localparam int ZW = $clog2(NUM_TAPS);
    state_t        state_next;
    logic [ZW-1:0] zcnt, zcnt_next;

    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        zcnt_next  = zcnt;
        zero_issue = 1'b0;
        tag_issue  = 1'b0;
        case (state)
            RUN: begin
                if (handshake && s_last) begin
                    state_next = FLUSH;
                    zcnt_next  = ZW'(NUM_TAPS - 1);
                end
            end
            FLUSH: begin
                if (has_credit) begin
                    zero_issue = 1'b1;
                    zcnt_next  = zcnt - ZW'(1);
                    if (zcnt == ZW'(1)) begin
                        tag_issue  = 1'b1;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN:   if (inflight == '0) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            zcnt  <= '0;
        end else begin
            state <= state_next;
            zcnt  <= zcnt_next;
        end
    end
`else
    assign state      = RUN;
    assign zero_issue = 1'b0;
    assign tag_issue  = handshake && s_last;
`endif

    always_comb begin
        inflight_next = inflight;
        if (issue && !fir_valid_out)      inflight_next = inflight + CW'(1);
        else if (!issue && fir_valid_out) inflight_next = inflight - CW'(1);
    end

    // FIFO with show-ahead head; push and pop may coincide even when full.
    assign tag_out = fir_valid_out && (last_pos == CW'(1));
    assign pop     = m_valid && m_ready;
    assign full    = (fifo_count == CW'(FIFO_DEPTH));
    assign push_ok = fir_valid_out && (!full || pop);
    assign drop    = fir_valid_out && full && !pop;

    always_comb begin
        fifo_count_next = fifo_count;
        if (push_ok && !pop)      fifo_count_next = fifo_count + CW'(1);
        else if (!push_ok && pop) fifo_count_next = fifo_count - CW'(1);
    end

    // NOTE: the storage array has no reset; m_valid qualifies the head and the outputs are gated.
    always_ff @(posedge clk) begin
        if (rst && push_ok) mem[wr_ptr] <= {tag_out, fir_dout};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight     <= '0;
            fifo_count   <= '0;
            last_pos     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fir_valid_in <= 1'b0;
            fir_din      <= '0;
            ovf_err      <= 1'b0;
        end else begin
            inflight     <= inflight_next;
            fifo_count   <= fifo_count_next;
            fir_valid_in <= issue;
            if (issue) fir_din <= zero_issue ? '0 : s_data;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (drop)    ovf_err <= 1'b1;
            if (tag_issue)                            last_pos <= inflight_next;
            else if (fir_valid_out && last_pos != '0) last_pos <= last_pos - CW'(1);
        end
    end

    assign head    = mem[rd_ptr];
    assign m_valid = (fifo_count != '0);
    assign m_data  = m_valid ? head[OUTPUT_WIDTH-1:0] : '0;
    assign m_last  = m_valid && head[OUTPUT_WIDTH];
    assign busy    = (state != RUN) || (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_fir_flow_ctrl.sv
// Self-checking bench for fir_flow_ctrl: the filter is a pure FIR_LATENCY delay of din*1, and a queue of
// expected results is built from accepted samples (plus the zero tail when FIR_FLOW_FLUSH_EN is defined).
module tb_fir_flow_ctrl;
    localparam int IW    = 16;
    localparam int OW    = 26;
    localparam int NT    = 37;
    localparam int LAT   = 8;
    localparam int DEPTH = 16;
`ifdef FIR_FLOW_FLUSH_EN
    localparam int TAIL = NT - 1;
`else
    localparam int TAIL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, s_valid, s_ready, s_last, fir_valid_in, fir_valid_out;
    logic          m_valid, m_ready, m_last, busy, ovf_err;
    logic [IW-1:0] s_data, fir_din;
    logic [OW-1:0] fir_dout, m_data;

    fir_flow_ctrl #(
        .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .NUM_TAPS(NT), .FIR_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .fir_valid_in(fir_valid_in), .fir_din(fir_din),
        .fir_valid_out(fir_valid_out), .fir_dout(fir_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] sext(input logic [IW-1:0] d);
        return {{(OW - IW){d[IW-1]}}, d};
    endfunction

    // Filter stand-in: unit-gain response, LAT cycles from valid_in to valid_out, shares the reset.
    logic [LAT-1:0] pv;
    logic [IW-1:0]  pd [LAT];
    always @(posedge clk) begin
        if (!rst) pv <= '0;
        else      pv <= {pv[LAT-2:0], fir_valid_in};
        pd[0] <= fir_din;
        for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
    end
    assign fir_valid_out = pv[LAT-1];
    assign fir_dout      = sext(pd[LAT-1]);

    int vectors = 0, miscompares = 0;
    int cyc = 0, outs = 0, hs_count = 0;
    int blk_outs = 0, blk_last_idx = 0, blk_last_cnt = 0, sready_viol = 0;
    int first_hs_cyc = 0, last_hs_cyc = 0, first_mv_cyc = 0, last_out_cyc = 0, outs_window = 0;
    bit hs_seen = 0, mv_seen = 0, flush_window = 0;
    logic [OW:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: observe at the falling edge, then return just after the rising edge for new stimulus.
    task automatic tick();
        logic [OW:0] e;
        @(negedge clk);
        cyc++;
        hs_seen = s_valid && s_ready;
        if (flush_window && s_ready) sready_viol++;
        if (hs_seen) begin
            hs_count++;
`ifdef FIR_FLOW_FLUSH_EN
            if (s_last) begin
                exp_q.push_back({1'b0, sext(s_data)});
                for (int k = 0; k < NT - 1; k++) exp_q.push_back({(k == NT - 2), OW'(0)});
                flush_window = 1;
            end else begin
                exp_q.push_back({1'b0, sext(s_data)});
            end
`else
            exp_q.push_back({s_last, sext(s_data)});
`endif
        end
        if (m_valid && m_ready) begin
            check("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("m_data", 64'(m_data), 64'(e[OW-1:0]));
                check("m_last", 64'(m_last), 64'(e[OW]));
            end
            outs++;
            blk_outs++;
            if (m_last) begin
                blk_last_cnt++;
                if (blk_last_idx == 0) blk_last_idx = blk_outs;
                flush_window = 0;
            end
            if (!mv_seen) begin
                mv_seen      = 1;
                first_mv_cyc = cyc;
            end
            last_out_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] d, input logic last);
        int budget = 200;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        do begin
            tick();
            budget--;
        end while (!hs_seen && budget > 0);
        check("send_accept", 64'(hs_seen), 64'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int budget = 600;
        while ((exp_q.size() != 0 || busy) && budget > 0) begin
            tick();
            budget--;
        end
        check(tag, 64'(exp_q.size() == 0 && !busy), 64'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"},      64'(s_ready), 64'd0);
        check({tag, "_m_valid"},      64'(m_valid), 64'd0);
        check({tag, "_m_data"},       64'(m_data), 64'd0);
        check({tag, "_m_last"},       64'(m_last), 64'd0);
        check({tag, "_fir_valid_in"}, 64'(fir_valid_in), 64'd0);
        check({tag, "_fir_din"},      64'(fir_din), 64'd0);
        check({tag, "_busy"},         64'(busy), 64'd0);
        check({tag, "_ovf_err"},      64'(ovf_err), 64'd0);
    endtask

    task automatic run_block(input int n, input string tag);
        blk_outs = 0; blk_last_idx = 0; blk_last_cnt = 0; sready_viol = 0;
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) send(IW'($urandom), (i == n - 1));
        wait_idle({tag, "_drain"});
        check({tag, "_outs"},       64'(blk_outs), 64'(n + TAIL));
        check({tag, "_last_idx"},   64'(blk_last_idx), 64'(n + TAIL));
        check({tag, "_last_cnt"},   64'(blk_last_cnt), 64'd1);
        check({tag, "_ready_held"}, 64'(sready_viol), 64'd0);
        check({tag, "_ready_back"}, 64'(s_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b1;
        tick();
        check("ready_after_reset", 64'(s_ready), 64'd1);

        // Streaming: 20 back-to-back samples, latency and gapless output.
        m_ready = 1'b1; outs = 0; mv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            send(IW'($urandom), 1'b0);
            if (i == 0)  first_hs_cyc = cyc;
            if (i == 19) last_hs_cyc  = cyc;
        end
        wait_idle("t1_drain");
        check("t1_outs",       64'(outs), 64'd20);
        check("t1_hs_span",    64'(last_hs_cyc - first_hs_cyc), 64'd19);
        check("t1_latency",    64'(first_mv_cyc - first_hs_cyc), 64'(LAT + 2));
        check("t1_out_span",   64'(last_out_cyc - first_mv_cyc), 64'd19);

        // Backpressure: credit admits exactly DEPTH samples, then resumes at full rate.
        m_ready = 1'b0; hs_count = 0; outs = 0; s_valid = 1'b1;
        repeat (40) begin
            s_data = IW'($urandom);
            tick();
        end
        check("t2_handshakes", 64'(hs_count), 64'(DEPTH));
        check("t2_s_ready",    64'(s_ready), 64'd0);
        check("t2_m_valid",    64'(m_valid), 64'd1);
        check("t2_ovf_err",    64'(ovf_err), 64'd0);
        m_ready = 1'b1;
        repeat (30) begin
            s_data = IW'($urandom);
            tick();
        end
        outs_window = outs;
        s_valid = 1'b0;
        wait_idle("t2_drain");
        check("t2_no_gaps",  64'(outs_window), 64'd30);
        check("t2_resumed",  64'(hs_count >= DEPTH + 25), 64'd1);
        check("t2_all_outs", 64'(outs), 64'(hs_count));

        // Random valid/ready traffic including full-FIFO push+pop and issue+return cycles.
        hs_count = 0; outs = 0;
        repeat (400) begin
            s_valid = ($urandom % 4) != 0;
            m_ready = ($urandom % 3) != 0;
            s_data  = IW'($urandom);
            s_last  = 1'b0;
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        wait_idle("t5_drain");
        check("t5_outs",    64'(outs), 64'(hs_count));
        check("t5_ovf_err", 64'(ovf_err), 64'd0);

        // Blocks ending in s_last.
        run_block(7, "blk7");
        run_block(5, "blk5");

        // Reset while results (and, with flush, the drain) are still in progress.
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(IW'($urandom), (i == 2));
        repeat (TAIL + 4) tick();
        check("t6_busy_before_reset", 64'(busy), 64'd1);
        rst = 1'b0;
        tick();
        exp_q.delete();
        flush_window = 0;
        check_reset("t6");
        rst = 1'b1;
        tick();
        check("t6_ready_after_release", 64'(s_ready), 64'd1);
        run_block(6, "t6_blk");
        check("final_ovf_err", 64'(ovf_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
